vga_console_writer: RTL and testbench

- Character-stream controller that drives the write port of the 40x30 text VGA block (vram_waddr / vram_wdata / vram_we).
- Accepts bytes over a valid/ready handshake and interprets control codes.
- Maintains a cursor and sequences all VRAM writes, including the full-screen clear after reset and on form feed.
- Sits between a CPU/UART byte source and the VGA block; runs on the VRAM write clock.

---
 rtl/vga_console_writer.sv | 218 +++++++++++++++++++++
 tb/tb_vga_console_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_console_writer.sv
// Byte-stream console controller for the 40x30 text VGA block: interprets control
// codes, tracks the cursor and sequences every VRAM write, including full-screen clears.
module vga_console_writer #(
   parameter int          COLS  = 40,
   parameter int          ROWS  = 30,
   parameter logic [15:0] BLANK = 16'h0020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_attr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [10:0] vram_waddr,
   output logic [15:0] vram_wdata,
   output logic        vram_we,
   output logic [5:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   localparam logic [10:0] LAST_IDX = 11'(COLS * ROWS - 1);
   localparam logic [10:0] COLS_A   = 11'(COLS);
   localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0]  COLS_T   = 7'(COLS);

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUT,
      OP_CR,
      OP_LF,
      OP_BS,
      OP_TAB,
      OP_FF
   } op_t;

   state_t      state_q, state_d;
   logic [10:0] clr_idx_q, clr_idx_d;
   logic [5:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [10:0] addr_q, addr_d;
   logic        vram_we_q, vram_we_d;
   logic [10:0] vram_waddr_q, vram_waddr_d;
   logic [15:0] vram_wdata_q, vram_wdata_d;
   logic        in_ready_q, in_ready_d;
   logic        busy_q, busy_d;

   logic        accept;
   op_t         op;
   logic        clear_last;
   logic [4:0]  row_next;
   logic [10:0] line_start;
   logic [10:0] next_line_addr;
   logic [6:0]  tab_col;
   logic        tab_wraps;

   assign accept     = (state_q == ST_RUN) && in_ready_q && in_valid;
   assign clear_last = (clr_idx_q == LAST_IDX);

   // Incremental address helpers: the linear address always tracks row*COLS+col.
   assign row_next       = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
   assign line_start     = addr_q - {5'd0, col_q};
   assign next_line_addr = (row_q == LAST_ROW) ? 11'd0 : addr_q + (COLS_A - {5'd0, col_q});
   assign tab_col        = {1'b0, col_q[5:3], 3'b000} + 7'd8;
   assign tab_wraps      = (tab_col >= COLS_T);

   // NOTE: every combinational process assigns all its outputs a default first, so no latches are inferred.
   always_comb begin
      op = OP_NONE;
      if (accept) begin
         case (in_data)
            8'h0D:   op = OP_CR;
            8'h0A:   op = OP_LF;
            8'h08:   op = OP_BS;
            8'h09:   op = OP_TAB;
            8'h0C:   op = OP_FF;
            8'h7F:   op = OP_NONE;
            default: op = (in_data >= 8'h20) ? OP_PUT : OP_NONE;
         endcase
      end
   end

   // State register; reset mid-operation drops any accepted byte not yet written.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clr_idx_q    <= 11'd0;
         col_q        <= 6'd0;
         row_q        <= 5'd0;
         addr_q       <= 11'd0;
         vram_we_q    <= 1'b0;
         vram_waddr_q <= 11'd0;
         vram_wdata_q <= 16'd0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         col_q        <= col_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         vram_we_q    <= vram_we_d;
         vram_waddr_q <= vram_waddr_d;
         vram_wdata_q <= vram_wdata_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + 11'd1;
            if (clear_last) begin
               state_d   = ST_RUN;
               clr_idx_d = 11'd0;
            end
         end
         ST_RUN: begin
            if (op == OP_FF) begin
               state_d   = ST_CLEAR;
               clr_idx_d = 11'd0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Output and cursor logic; every output is registered from these _d values.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      addr_d       = addr_q;
      vram_we_d    = 1'b0;
      vram_waddr_d = vram_waddr_q;
      vram_wdata_d = vram_wdata_q;
      in_ready_d   = 1'b0;
      busy_d       = 1'b1;
      case (state_q)
         ST_CLEAR: begin
            vram_we_d    = 1'b1;
            vram_waddr_d = clr_idx_q;
            vram_wdata_d = BLANK;
            if (clear_last) begin
               col_d  = 6'd0;
               row_d  = 5'd0;
               addr_d = 11'd0;
            end
         end
         ST_RUN: begin
            // in_ready stays low on the first RUN cycle, so it rises one cycle after the last clear write.
            in_ready_d = (op != OP_FF);
            busy_d     = (op == OP_FF);
            case (op)
               OP_PUT: begin
                  vram_we_d    = 1'b1;
                  vram_waddr_d = addr_q;
                  vram_wdata_d = {in_attr, in_data};
                  if (col_q == LAST_COL) begin
                     col_d  = 6'd0;
                     row_d  = row_next;
                     addr_d = next_line_addr;
                  end else begin
                     col_d  = col_q + 6'd1;
                     addr_d = addr_q + 11'd1;
                  end
               end
               OP_CR: begin
                  col_d  = 6'd0;
                  addr_d = line_start;
               end
               OP_LF: begin
                  col_d  = 6'd0;
                  row_d  = row_next;
                  addr_d = next_line_addr;
               end
               OP_BS: begin
                  if (col_q != 6'd0) begin
                     col_d  = col_q - 6'd1;
                     addr_d = addr_q - 11'd1;
                  end
               end
               OP_TAB: begin
                  if (tab_wraps) begin
                     col_d  = 6'd0;
                     row_d  = row_next;
                     addr_d = next_line_addr;
                  end else begin
                     col_d  = tab_col[5:0];
                     addr_d = addr_q + {4'd0, tab_col - {1'b0, col_q}};
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign in_ready   = in_ready_q;
   assign vram_we    = vram_we_q;
   assign vram_waddr = vram_waddr_q;
   assign vram_wdata = vram_wdata_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: clears, printable writes, control codes,
// cursor wrap and reset during a clear, with hand-computed expectations.
module tb_vga_console_writer;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic [7:0]  in_attr;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] vram_waddr;
   logic [15:0] vram_wdata;
   logic        vram_we;
   logic [5:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;

   vga_console_writer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_attr    (in_attr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .vram_waddr (vram_waddr),
      .vram_wdata (vram_wdata),
      .vram_we    (vram_we),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [10:0] waddr,
                             input logic [15:0] wdata, input logic [5:0] col, input logic [4:0] row);
      chk({tag, "_we"}, 32'(vram_we), 32'(we));
      if (we) begin
         chk({tag, "_waddr"}, 32'(vram_waddr), 32'(waddr));
         chk({tag, "_wdata"}, 32'(vram_wdata), 32'(wdata));
      end
      chk({tag, "_col"}, 32'(cursor_col), 32'(col));
      chk({tag, "_row"}, 32'(cursor_row), 32'(row));
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic send(input logic [7:0] d, input logic [7:0] a);
      in_data  = d;
      in_attr  = a;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Expects 1200 gap-free blank writes from address 0, then the RUN handover cycle.
   task automatic run_clear(input string tag);
      int bad = 0;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (vram_we !== 1'b1 || vram_waddr !== 11'(i) || vram_wdata !== 16'h0020 ||
             in_ready !== 1'b0 || busy !== 1'b1)
            bad++;
      end
      chk({tag, "_clear_cycles_bad"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      expect_out({tag, "_after"}, 1'b0, 11'd0, 16'd0, 6'd0, 5'd0);
   endtask

   initial begin
      int bad;
      reset    = 1'b1;
      in_data  = 8'h00;
      in_attr  = 8'h00;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_we", 32'(vram_we), 32'd0);
      chk("rst_waddr", 32'(vram_waddr), 32'd0);
      chk("rst_wdata", 32'(vram_wdata), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_col", 32'(cursor_col), 32'd0);
      chk("rst_row", 32'(cursor_row), 32'd0);
      reset = 1'b0;
      run_clear("boot");

      // First printable byte
      send(8'h41, 8'h07);
      expect_out("put_A", 1'b1, 11'd0, 16'h0741, 6'd1, 5'd0);

      // Back to column 0, then stream 41 bytes back to back
      send(8'h0D, 8'h00);
      expect_out("cr_home", 1'b0, 11'd0, 16'd0, 6'd0, 5'd0);
      bad = 0;
      for (int i = 0; i < 41; i++) begin
         in_data  = 8'(8'h21 + i);
         in_attr  = 8'h1E;
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (vram_we !== 1'b1 || vram_waddr !== 11'(i) || vram_wdata !== {8'h1E, 8'(8'h21 + i)})
            bad++;
      end
      in_valid = 1'b0;
      chk("stream41_bad", 32'(bad), 32'd0);
      expect_out("stream41_end", 1'b1, 11'd40, {8'h1E, 8'h49}, 6'd1, 5'd1);
      @(negedge clk);
      chk("idle_no_we", 32'(vram_we), 32'd0);

      // Walk to (39,29) and write the last cell
      repeat (28) send(8'h0A, 8'h00);
      repeat (4) send(8'h09, 8'h00);
      repeat (7) send(8'h2E, 8'h02);
      expect_out("at_39_29", 1'b1, 11'd1198, 16'h022E, 6'd39, 5'd29);
      send(8'h5A, 8'h4F);
      expect_out("last_cell", 1'b1, 11'd1199, 16'h4F5A, 6'd0, 5'd0);

      // Control codes from (10,3)
      repeat (3) send(8'h0A, 8'h00);
      repeat (10) send(8'h2D, 8'h03);
      expect_out("at_10_3", 1'b1, 11'd129, 16'h032D, 6'd10, 5'd3);
      send(8'h09, 8'hFF);
      expect_out("tab_16", 1'b0, 11'd0, 16'd0, 6'd16, 5'd3);
      send(8'h08, 8'hFF);
      expect_out("bs_15", 1'b0, 11'd0, 16'd0, 6'd15, 5'd3);
      send(8'h0D, 8'hFF);
      expect_out("cr_0", 1'b0, 11'd0, 16'd0, 6'd0, 5'd3);
      send(8'h0A, 8'hFF);
      expect_out("lf_0_4", 1'b0, 11'd0, 16'd0, 6'd0, 5'd4);
      send(8'h08, 8'hFF);
      expect_out("bs_at_0", 1'b0, 11'd0, 16'd0, 6'd0, 5'd4);
      repeat (4) send(8'h09, 8'h00);
      repeat (3) send(8'h23, 8'h05);
      expect_out("at_35_4", 1'b1, 11'd194, 16'h0523, 6'd35, 5'd4);
      send(8'h09, 8'h00);
      expect_out("tab_wrap", 1'b0, 11'd0, 16'd0, 6'd0, 5'd5);
      send(8'h71, 8'h0A);
      expect_out("addr_after_ctrl", 1'b1, 11'd200, 16'h0A71, 6'd1, 5'd5);

      // Ignored codes
      send(8'h00, 8'h55);
      expect_out("nul_ignored", 1'b0, 11'd0, 16'd0, 6'd1, 5'd5);
      send(8'h7F, 8'h55);
      expect_out("del_ignored", 1'b0, 11'd0, 16'd0, 6'd1, 5'd5);
      send(8'h72, 8'h0B);
      expect_out("addr_after_ign", 1'b1, 11'd201, 16'h0B72, 6'd2, 5'd5);

      // Form feed mid-line with in_valid held through the clear
      send(8'h0C, 8'h00);
      chk("ff_ready_drop", 32'(in_ready), 32'd0);
      chk("ff_busy", 32'(busy), 32'd1);
      chk("ff_no_we", 32'(vram_we), 32'd0);
      in_data  = 8'h4D;
      in_attr  = 8'h21;
      in_valid = 1'b1;
      run_clear("ff");
      @(negedge clk);
      in_valid = 1'b0;
      expect_out("ff_first_put", 1'b1, 11'd0, 16'h214D, 6'd1, 5'd0);

      // Reset in the middle of a clear restarts it from address 0
      send(8'h0C, 8'h00);
      repeat (600) @(negedge clk);
      chk("midclr_we_before", 32'(vram_we), 32'd1);
      chk("midclr_addr_before", 32'(vram_waddr), 32'd599);
      reset = 1'b1;
      @(negedge clk);
      chk("midclr_rst_we", 32'(vram_we), 32'd0);
      chk("midclr_rst_busy", 32'(busy), 32'd1);
      chk("midclr_rst_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      run_clear("restart");
      send(8'h45, 8'h70);
      expect_out("restart_put", 1'b1, 11'd0, 16'h7045, 6'd1, 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
